// File: rtl/sshooter_audio_mixer.sv
// Final mixer for the Scooter Shooter sound board: FM plus three PSG channels, each with a gain,
// summed through one shared multiplier, then scaled, saturated and emitted once every DIV clocks.
module sshooter_audio_mixer #(
   parameter int DIV        = 128,
   parameter int GAIN_SHIFT = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] fm_in,
   input  logic signed [15:0] psg_a,
   input  logic signed [15:0] psg_b,
   input  logic signed [15:0] psg_c,
   input  logic        [7:0]  gain_fm,
   input  logic        [7:0]  gain_a,
   input  logic        [7:0]  gain_b,
   input  logic        [7:0]  gain_c,
   input  logic               mute,
   input  logic               clip_clr,
   output logic signed [15:0] out,
   output logic               out_valid,
   output logic               clip
);

   localparam int                    CNT_W    = 10;
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIV - 1);
   localparam logic signed [26:0]    MAX16    = 27'sd32767;
   localparam logic signed [26:0]    MIN16    = -27'sd32768;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      SAT  = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        count_reg, count_next;
   logic [1:0]              idx_reg, idx_next;
   logic signed [26:0]      acc_reg, acc_next;
   logic signed [15:0]      out_reg, out_next;
   logic                    out_valid_reg, out_valid_next;
   logic                    clip_reg, clip_next;

   logic                    snap_en;
   logic signed [15:0]      sample_in [4];
   logic        [7:0]       gain_in   [4];
   logic signed [15:0]      snap_sample [4];
   logic        [7:0]       snap_gain   [4];

   // Index order fixes the accumulation order: fm, a, b, c.
   assign sample_in[0] = fm_in;
   assign sample_in[1] = psg_a;
   assign sample_in[2] = psg_b;
   assign sample_in[3] = psg_c;
   assign gain_in[0]   = gain_fm;
   assign gain_in[1]   = gain_a;
   assign gain_in[2]   = gain_b;
   assign gain_in[3]   = gain_c;

   assign snap_en = (count_reg == CNT_LAST);

   // Snapshot registers isolate the sample in flight from later input changes.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_snap
         logic signed [15:0] sample_reg;
         logic        [7:0]  gain_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               sample_reg <= '0;
               gain_reg   <= '0;
            end else if (snap_en) begin
               sample_reg <= sample_in[gi];
               gain_reg   <= gain_in[gi];
            end
         end

         assign snap_sample[gi] = sample_reg;
         assign snap_gain[gi]   = gain_reg;
      end
   endgenerate

   // Shared multiplier: 16-bit signed sample times zero-extended 8-bit gain.
   logic signed [24:0] sample_ext;
   logic signed [24:0] gain_ext;
   logic signed [24:0] product;

   assign sample_ext = 25'(snap_sample[idx_reg]);
   assign gain_ext   = {17'd0, snap_gain[idx_reg]};
   assign product    = sample_ext * gain_ext;

   logic signed [26:0] shifted;
   logic               pos_ovf;
   logic               neg_ovf;
   logic signed [15:0] sat_value;

   assign shifted = acc_reg >>> GAIN_SHIFT;
   assign pos_ovf = (shifted > MAX16);
   assign neg_ovf = (shifted < MIN16);

   always_comb begin
      sat_value = shifted[15:0];
      if (pos_ovf) begin
         sat_value = 16'sh7fff;
      end else if (neg_ovf) begin
         sat_value = 16'sh8000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         idx_reg       <= '0;
         acc_reg       <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
         clip_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         idx_reg       <= idx_next;
         acc_reg       <= acc_next;
         out_reg       <= out_next;
         out_valid_reg <= out_valid_next;
         clip_reg      <= clip_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = (count_reg == CNT_LAST) ? '0 : count_reg + 1'b1;
      idx_next       = idx_reg;
      acc_next       = acc_reg;
      out_next       = out_reg;
      out_valid_next = 1'b0;
      clip_next      = clip_reg;

      if (clip_clr) begin
         clip_next = 1'b0;
      end

      case (state_reg)
         MAC: begin
            acc_next = acc_reg + 27'(product);
            idx_next = idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
               state_next = SAT;
            end
         end
         SAT: begin
            out_valid_next = 1'b1;
            state_next     = IDLE;
            if (mute) begin
               out_next = '0;
            end else begin
               out_next = sat_value;
               // A saturation event outranks a simultaneous clear.
               if (pos_ovf || neg_ovf) begin
                  clip_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // DIV >= 8 guarantees the previous sequence has finished by the snapshot edge.
      if (snap_en) begin
         acc_next   = '0;
         idx_next   = '0;
         state_next = MAC;
      end
   end

   assign out       = out_reg;
   assign out_valid = out_valid_reg;
   assign clip      = clip_reg;

endmodule

// File: tb/tb_sshooter_audio_mixer.sv
// Scoreboard bench for sshooter_audio_mixer: expected samples are queued at the snapshot edge
// and compared when out_valid pulses, along with pulse timing, hold, clip and reset behaviour.
module tb_sshooter_audio_mixer;

   localparam int DIV = 128;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [15:0] fm_in, psg_a, psg_b, psg_c;
   logic        [7:0]  gain_fm, gain_a, gain_b, gain_c;
   logic               mute, clip_clr;
   logic signed [15:0] out;
   logic               out_valid, clip;

   sshooter_audio_mixer #(.DIV(DIV), .GAIN_SHIFT(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .fm_in     (fm_in),
      .psg_a     (psg_a),
      .psg_b     (psg_b),
      .psg_c     (psg_c),
      .gain_fm   (gain_fm),
      .gain_a    (gain_a),
      .gain_b    (gain_b),
      .gain_c    (gain_c),
      .mute      (mute),
      .clip_clr  (clip_clr),
      .out       (out),
      .out_valid (out_valid),
      .clip      (clip)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_out_q[$];
   int exp_clip_q[$];
   int edge_cnt;
   int mon_out, mon_clip;
   bit prev_valid = 1'b0;

   // Edges since reset release: snapshot edges are multiples of DIV.
   always @(posedge clk) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         check("valid_time", int'((edge_cnt >= DIV + 5) && (((edge_cnt - 5) % DIV) == 0)), 1);
         if (exp_out_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            mon_out  = exp_out_q.pop_front();
            mon_clip = exp_clip_q.pop_front();
            check("out", int'(out), mon_out);
            check("clip", int'(clip), mon_clip);
         end
         if (prev_valid) check("valid_width", 2, 1);
      end
      prev_valid = out_valid;
   end

   task automatic wait_e0();
      int guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while ((((edge_cnt + 1) % DIV) != 0) && (guard < 2 * DIV));
      if (guard >= 2 * DIV) check("e0_wait", 0, 1);
   endtask

   task automatic run_sample(input int fm, input int a, input int b, input int c,
                             input int gf, input int ga, input int gb, input int gc,
                             input bit m, input int fm_after, input bit clr_e5,
                             input int exp_o, input int exp_c);
      wait_e0();
      fm_in   = 16'(fm);
      psg_a   = 16'(a);
      psg_b   = 16'(b);
      psg_c   = 16'(c);
      gain_fm = 8'(gf);
      gain_a  = 8'(ga);
      gain_b  = 8'(gb);
      gain_c  = 8'(gc);
      mute    = m;
      exp_out_q.push_back(exp_o);
      exp_clip_q.push_back(exp_c);
      @(negedge clk);
      fm_in = 16'(fm_after);
      repeat (4) @(negedge clk);
      clip_clr = clr_e5;
      @(negedge clk);
      clip_clr = 1'b0;
      @(negedge clk);
      check("hold", int'(out), exp_o);
      check("valid_low", int'(out_valid), 0);
   endtask

   task automatic clear_clip();
      clip_clr = 1'b1;
      @(negedge clk);
      clip_clr = 1'b0;
      check("clip_clr", int'(clip), 0);
   endtask

   task automatic reset_mid_mac();
      wait_e0();
      fm_in   = 16'sd7000;
      gain_fm = 8'd64;
      mute    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_out", int'(out), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_clip", int'(clip), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      fm_in    = '0;  psg_a  = '0;  psg_b  = '0;  psg_c  = '0;
      gain_fm  = '0;  gain_a = '0;  gain_b = '0;  gain_c = '0;
      mute     = 1'b0;
      clip_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_out", int'(out), 0);
      check("reset_valid", int'(out_valid), 0);
      check("reset_clip", int'(clip), 0);
      reset = 1'b0;

      //          fm      a     b      c    gf   ga  gb   gc  mute after  clr  exp     clip
      run_sample(1000,    0,    0,     0,   64,  0,  0,   0,  0,   1000,  0,   1000,   0);
      run_sample(100,     0,    0,     0,   32,  0,  0,   0,  0,   100,   0,   50,     0);
      run_sample(-1,      0,    0,     0,   1,   0,  0,   0,  0,   -1,    0,   -1,     0);
      run_sample(-100,    0,    0,     0,   1,   0,  0,   0,  0,   -100,  0,   -2,     0);
      run_sample(1000,   -400,  200,   0,   64,  64, 128, 0,  0,   1000,  0,   1000,   0);
      run_sample(30000,  30000, 30000, 30000, 64, 64, 64, 64, 0,  30000, 0,   32767,  1);
      run_sample(0,       0,    0,     0,   64,  64, 64,  64, 0,   0,     0,   0,      1);
      clear_clip();
      run_sample(1000,    0,    0,     0,   64,  0,  0,   0,  0,   5000,  0,   1000,   0);
      run_sample(5000,    0,    0,     0,   64,  0,  0,   0,  0,   5000,  0,   5000,   0);
      run_sample(5000,    0,    0,     0,   64,  0,  0,   0,  1,   5000,  0,   0,      0);
      run_sample(-32768,  0,    0,     0,   255, 0,  0,   0,  0,  -32768, 1,  -32768,  1);
      reset_mid_mac();
      run_sample(1234,    0,    0,     0,   64,  0,  0,   0,  0,   1234,  0,   1234,   0);

      repeat (2) @(negedge clk);
      check("drain", exp_out_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
